cavlc_coeff_scan: RTL and testbench

CAVLC_COEFF_SCAN -- requirements
Module: cavlc_coeff_scan

---
 rtl/cavlc_pkg.sv | 18 +
 rtl/cavlc_coeff_scan.sv | 150 +++++++++++++++
 tb/tb_cavlc_coeff_scan.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/cavlc_pkg.sv
// cavlc_pkg -- shared definitions for the CAVLC coefficient scan block.
//   cWIDTH_DFLT / aWIDTH_DFLT : default coefficient and tz_addr widths
//   BLOCK_LEN                 : coefficients per 4x4 block
//   MAX_T1                    : saturation value of the trailing-ones count
//   scan_state_e              : scan FSM state type
package cavlc_pkg;

    localparam int cWIDTH_DFLT = 16;
    localparam int aWIDTH_DFLT = 8;
    localparam int BLOCK_LEN   = 16;
    localparam int MAX_T1      = 3;

    typedef enum logic {
        SCAN = 1'b0,
        DONE = 1'b1
    } scan_state_e;

endpackage

// File: rtl/cavlc_coeff_scan.sv
// cavlc_coeff_scan -- accumulates CAVLC block statistics over one 4x4 block
// of quantised coefficients delivered in zigzag order, one per accepted beat.
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid/in_ready   : coefficient input handshake
//   coeff_in            : signed coefficient, DC first
//   out_valid/out_ready : statistics output handshake (held until accepted)
//   total_coeff         : non-zero count 0..16
//   total_zeros         : zeros before the last non-zero 0..15
//   trailing_ones       : trailing +/-1 count 0..3
//   t1_signs            : trailing-one signs, bit0 = last (highest-frequency) one
//   tz_addr, tz_skip    : total-zeros table address and "no code" flag
module cavlc_coeff_scan
    import cavlc_pkg::*;
#(
    parameter int cWIDTH = cWIDTH_DFLT,
    parameter int aWIDTH = aWIDTH_DFLT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [cWIDTH-1:0] coeff_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [4:0]               total_coeff,
    output logic [3:0]               total_zeros,
    output logic [1:0]               trailing_ones,
    output logic [2:0]               t1_signs,
    output logic [aWIDTH-1:0]        tz_addr,
    output logic                     tz_skip
);

    scan_state_e state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [4:0]  tc_q, tc_d;
    logic [3:0]  last_nz_q, last_nz_d;
    logic [1:0]  t1_q, t1_d;
    logic [2:0]  sgn_q, sgn_d;

    logic accept;
    logic is_nz;
    logic is_one;
    logic last_beat;

    assign accept    = in_valid && in_ready;
    assign last_beat = (idx_q == 4'(BLOCK_LEN - 1));
    assign is_nz     = (coeff_in != '0);
    // Equality tests only, so the most negative value never needs negating
    // and falls out naturally as "magnitude > 1".
    assign is_one    = (coeff_in == cWIDTH'(1)) || (coeff_in == '1);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= SCAN;
        else     state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            SCAN: if (accept && last_beat) state_d = DONE;
            DONE: if (out_ready)           state_d = SCAN;
            default:                       state_d = SCAN;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        in_ready  = (state_q == SCAN);
        out_valid = (state_q == DONE);
    end

    // ---------------- accumulators ----------------
    always_comb begin
        idx_d     = idx_q;
        tc_d      = tc_q;
        last_nz_d = last_nz_q;
        t1_d      = t1_q;
        sgn_d     = sgn_q;
        if (state_q == DONE && out_ready) begin
            // Returning to SCAN: start the next block clean.
            idx_d     = '0;
            tc_d      = '0;
            last_nz_d = '0;
            t1_d      = '0;
            sgn_d     = '0;
        end else if (accept) begin
            idx_d = idx_q + 4'd1;
            if (is_nz) begin
                tc_d      = tc_q + 5'd1;
                last_nz_d = idx_q;
                if (is_one) begin
                    t1_d  = (t1_q == 2'(MAX_T1)) ? t1_q : t1_q + 2'd1;
                    sgn_d = {sgn_q[1:0], coeff_in[cWIDTH-1]};
                end else begin
                    t1_d  = '0;
                    sgn_d = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q     <= '0;
            tc_q      <= '0;
            last_nz_q <= '0;
            t1_q      <= '0;
            sgn_q     <= '0;
        end else begin
            idx_q     <= idx_d;
            tc_q      <= tc_d;
            last_nz_q <= last_nz_d;
            t1_q      <= t1_d;
            sgn_q     <= sgn_d;
        end
    end

    // ---------------- derived statistics ----------------
    logic [3:0] tz_raw;
    logic [3:0] tc_m1;
    logic [2:0] sgn_mask;
    logic       skip_raw;
    logic       done;

    always_comb begin
        done     = (state_q == DONE);
        tz_raw   = (tc_q == 5'd0) ? 4'd0
                                  : 4'({1'b0, last_nz_q} + 5'd1 - tc_q);
        tc_m1    = 4'(tc_q - 5'd1);
        skip_raw = (tc_q == 5'd0) || (tc_q == 5'(BLOCK_LEN));
        case (t1_q)
            2'd0:    sgn_mask = 3'b000;
            2'd1:    sgn_mask = 3'b001;
            2'd2:    sgn_mask = 3'b011;
            default: sgn_mask = 3'b111;
        endcase

        // Statistics are only presented while DONE; elsewhere they read 0 so
        // the consumer never sees a partial block.
        total_coeff   = done ? tc_q : 5'd0;
        total_zeros   = done ? tz_raw : 4'd0;
        trailing_ones = done ? t1_q : 2'd0;
        t1_signs      = done ? (sgn_q & sgn_mask) : 3'd0;
        tz_skip       = done && skip_raw;
        tz_addr       = (done && !skip_raw) ? aWIDTH'({tc_m1, tz_raw}) : '0;
    end

endmodule

// File: tb/tb_cavlc_coeff_scan.sv
module tb_cavlc_coeff_scan;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] coeff_in;
    logic               out_valid;
    logic               out_ready;
    logic [4:0]         total_coeff;
    logic [3:0]         total_zeros;
    logic [1:0]         trailing_ones;
    logic [2:0]         t1_signs;
    logic [7:0]         tz_addr;
    logic               tz_skip;

    int checks   = 0;
    int failures = 0;

    logic signed [15:0] blk [16];

    always #5 clk = ~clk;

    cavlc_coeff_scan #(.cWIDTH(16), .aWIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .coeff_in(coeff_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .total_coeff(total_coeff), .total_zeros(total_zeros),
        .trailing_ones(trailing_ones), .t1_signs(t1_signs),
        .tz_addr(tz_addr), .tz_skip(tz_skip)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_stats(input string tag, input int tc, input int tz, input int t1,
                             input int sg, input int addr, input int skip);
        chk({tag, ".tc"},   32'(total_coeff),   32'(tc));
        chk({tag, ".tz"},   32'(total_zeros),   32'(tz));
        chk({tag, ".t1"},   32'(trailing_ones), 32'(t1));
        chk({tag, ".sg"},   32'(t1_signs),      32'(sg));
        chk({tag, ".addr"}, 32'(tz_addr),       32'(addr));
        chk({tag, ".skip"}, 32'(tz_skip),       32'(skip));
    endtask

    // Sends blk[] as 16 back-to-back beats; checks latency-1 out_valid.
    task automatic send_blk(input string tag);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk({tag, ".rdy"}, 32'(in_ready), 32'd1);
            in_valid = 1'b1;
            coeff_in = blk[i];
        end
        @(negedge clk);
        in_valid = 1'b0;
        coeff_in = '0;
        chk({tag, ".ov"},  32'(out_valid), 32'd1);
        chk({tag, ".ir"},  32'(in_ready),  32'd0);
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, ".hs_ov"}, 32'(out_valid), 32'd0);
        chk({tag, ".hs_ir"}, 32'(in_ready),  32'd1);
    endtask

    task automatic load_035();
        for (int i = 0; i < 16; i++) blk[i] = 16'sd0;
        blk[1] = 16'sd3;  blk[3] = 16'sd1;  blk[4] = -16'sd1;
        blk[5] = -16'sd1; blk[7] = 16'sd1;
    endtask

    task automatic load_038();
        for (int i = 0; i < 16; i++) blk[i] = 16'sd0;
        blk[15] = -16'sd1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; coeff_in = '0; out_ready = 1'b0;
        @(negedge clk);
        chk("rst.ir", 32'(in_ready),  32'd1);
        chk("rst.ov", 32'(out_valid), 32'd0);
        chk_stats("rst", 0, 0, 0, 0, 0, 0);
        rst = 1'b0;

        // Mixed block: 5 non-zeros, last at index 7, three trailing ones.
        load_035();
        send_blk("b035");
        chk_stats("b035", 5, 3, 3, 3'b110, 8'h43, 0);
        handshake("b035");

        // All zeros.
        for (int i = 0; i < 16; i++) blk[i] = 16'sd0;
        send_blk("b036");
        chk_stats("b036", 0, 0, 0, 0, 8'h00, 1);
        handshake("b036");

        // All twos: full block, no trailing ones.
        for (int i = 0; i < 16; i++) blk[i] = 16'sd2;
        send_blk("b037");
        chk_stats("b037", 16, 0, 0, 0, 8'h00, 1);
        handshake("b037");

        // Single -1 at the last position.
        load_038();
        send_blk("b038");
        chk_stats("b038", 1, 15, 1, 3'b001, 8'h0F, 0);
        handshake("b038");

        // Most negative value counts as magnitude > 1 and clears trailing ones;
        // four ones saturate at 3 keeping the last three signs.
        for (int i = 0; i < 16; i++) blk[i] = 16'sd0;
        blk[0] = -16'sd1; blk[1] = 16'sh8000; blk[2] = 16'sd1;
        blk[3] = -16'sd1; blk[4] = -16'sd1; blk[5] = 16'sd1; blk[6] = -16'sd1;
        send_blk("sat");
        chk_stats("sat", 7, 0, 3, 3'b101, 8'h60, 0);
        handshake("sat");

        // Back-pressure: DONE held while in_valid is asserted.
        load_038();
        send_blk("bp");
        in_valid = 1'b1;
        coeff_in = 16'sd5;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp.ir", 32'(in_ready),  32'd0);
            chk("bp.ov", 32'(out_valid), 32'd1);
            chk_stats("bp", 1, 15, 1, 3'b001, 8'h0F, 0);
        end
        in_valid = 1'b0;
        coeff_in = '0;
        handshake("bp");
        load_035();
        send_blk("bp2");
        chk_stats("bp2", 5, 3, 3, 3'b110, 8'h43, 0);
        handshake("bp2");

        // Reset mid-block after 7 beats.
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            coeff_in = 16'sd2;
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("mrst.ir", 32'(in_ready),  32'd1);
        chk("mrst.ov", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        load_038();
        send_blk("b040");
        chk_stats("b040", 1, 15, 1, 3'b001, 8'h0F, 0);
        handshake("b040");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
